lte_reject_flood_detector: RTL and testbench

- Parametrised successor to the single-shot LTE reject-message IDS engine.
- Reads a message trace from the shared SRAM under the dut_valid/dut_ready handshake.
- Counts NAS reject codes per type and flags an attack when any type reaches a configurable threshold.
- Writes a result word containing the attack code and the triggering message index, then returns ready.

---
 rtl/lte_reject_flood_detector.sv | 129 ++++++++++++
 tb/tb_lte_reject_flood_detector.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/lte_reject_flood_detector.sv
// lte_reject_flood_detector: counts NAS reject codes from an SRAM trace and writes the first flood detection.
// Define IDS_STATS_EN to also write the final per-type counters after the result word.
module lte_reject_flood_detector #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_TYPES  = 4,
    parameter int CNT_WIDTH  = 8,
    parameter int THRESHOLD  = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  dut_valid,
    output logic                  dut_ready,
    output logic                  sram_write_enable,
    output logic [ADDR_WIDTH-1:0] sram_write_address,
    output logic [DATA_WIDTH-1:0] sram_write_data,
    output logic [ADDR_WIDTH-1:0] sram_read_address,
    input  logic [DATA_WIDTH-1:0] sram_read_data
);
`ifdef IDS_STATS_EN
    typedef enum logic [2:0] {IDLE, RD_HDR, RD_LEN, RD_MSG, DRAIN, WRITE, STATS} state_t;
    localparam int TW = $clog2(NUM_TYPES + 1);
    logic [TW-1:0]         stat_t;
    logic [DATA_WIDTH-1:0] stat_word;
`else
    typedef enum logic [2:0] {IDLE, RD_HDR, RD_LEN, RD_MSG, DRAIN, WRITE} state_t;
`endif
    localparam logic [ADDR_WIDTH-1:0] N_MAX   = ADDR_WIDTH'((1 << ADDR_WIDTH) - 2 - NUM_TYPES);
    localparam logic [ADDR_WIDTH-1:0] ONE     = ADDR_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0]  CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0]  THR     = CNT_WIDTH'(THRESHOLD);

    state_t                state, state_d;
    logic [ADDR_WIDTH-1:0] n, len_in, msg_idx, attack_idx;
    logic [7:0]            attack_code;
    logic                  msg_v;
    logic [CNT_WIDTH-1:0]  cnt [NUM_TYPES];
    logic [DATA_WIDTH-1:0] result;
    logic                  unused_ok;

    assign unused_ok = ^sram_read_data;
    assign len_in = (sram_read_data[ADDR_WIDTH-1:0] > N_MAX) ? N_MAX : sram_read_data[ADDR_WIDTH-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    state_d = dut_valid ? RD_HDR : IDLE;
            RD_HDR:  state_d = RD_LEN;
            RD_LEN:  state_d = (len_in == '0) ? DRAIN : RD_MSG;
            RD_MSG:  state_d = (sram_read_address == n) ? DRAIN : RD_MSG;
            DRAIN:   state_d = WRITE;
`ifdef IDS_STATS_EN
            WRITE:   state_d = STATS;
            STATS:   state_d = (stat_t == TW'(NUM_TYPES)) ? IDLE : STATS;
`else
            WRITE:   state_d = IDLE;
`endif
            default: state_d = IDLE;
        endcase
    end

    // Message data lags its address by one cycle, so msg_v/msg_idx tag the datum on the bus.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sram_read_address <= '0;
            n                 <= '0;
            msg_v             <= 1'b0;
            msg_idx           <= '0;
            attack_code       <= '0;
            attack_idx        <= '0;
            for (int t = 0; t < NUM_TYPES; t++) cnt[t] <= '0;
`ifdef IDS_STATS_EN
            stat_t            <= '0;
`endif
        end else begin
            msg_v   <= (state == RD_MSG);
            msg_idx <= sram_read_address;
            if (state == IDLE && dut_valid) begin
                sram_read_address <= '0;
                attack_code       <= '0;
                attack_idx        <= '0;
                for (int t = 0; t < NUM_TYPES; t++) cnt[t] <= '0;
            end
            if (state == RD_LEN) begin
                n <= len_in;
                if (len_in != '0) sram_read_address <= ONE;
            end
            if (state == RD_MSG && sram_read_address != n) sram_read_address <= sram_read_address + ONE;
            if (msg_v)
                for (int t = 0; t < NUM_TYPES; t++)
                    if (sram_read_data[7:0] == 8'(t + 1) && cnt[t] != CNT_MAX) begin
                        cnt[t] <= cnt[t] + 1'b1;
                        if (attack_code == '0 && cnt[t] + 1'b1 == THR) begin
                            attack_code <= 8'(t + 1);
                            attack_idx  <= msg_idx;
                        end
                    end
`ifdef IDS_STATS_EN
            if (state == WRITE) stat_t <= TW'(1);
            if (state == STATS) stat_t <= stat_t + 1'b1;
`endif
        end
    end

    always_comb begin
        result          = '0;
        result[7:0]     = attack_code;
        result[31:16]   = 16'(attack_idx);
        dut_ready          = (state == IDLE);
        sram_write_enable  = (state == WRITE);
        sram_write_address = sram_write_enable ? n + ONE : '0;
        sram_write_data    = sram_write_enable ? result : '0;
`ifdef IDS_STATS_EN
        stat_word = '0;
        for (int t = 0; t < NUM_TYPES; t++)
            if (stat_t == TW'(t + 1)) stat_word = DATA_WIDTH'(cnt[t]);
        if (state == STATS) begin
            sram_write_enable  = 1'b1;
            sram_write_address = n + ONE + ADDR_WIDTH'(stat_t);
            sram_write_data    = stat_word;
        end
`endif
    end
endmodule

// File: tb/tb_lte_reject_flood_detector.sv
// tb_lte_reject_flood_detector: directed and random traces checked against a behavioural flood model.
module tb_lte_reject_flood_detector;
    localparam int AW = 16;
    localparam int DW = 32;
    localparam int NT = 4;
    localparam int THR = 3;
`ifdef IDS_STATS_EN
    localparam int EXTRA = NT;
`else
    localparam int EXTRA = 0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          dut_valid = 1'b0;
    logic          dut_ready;
    logic          sram_write_enable;
    logic [AW-1:0] sram_write_address;
    logic [DW-1:0] sram_write_data;
    logic [AW-1:0] sram_read_address;
    logic [DW-1:0] sram_read_data = '0;

    logic [31:0] mem [0:65535];
    logic [AW-1:0] wa_q[$];
    logic [DW-1:0] wd_q[$];
    int n_cmp = 0;
    int n_err = 0;
    int exp_cnt [NT+1];

    lte_reject_flood_detector dut (
        .clk(clk), .reset(reset), .dut_valid(dut_valid), .dut_ready(dut_ready),
        .sram_write_enable(sram_write_enable), .sram_write_address(sram_write_address),
        .sram_write_data(sram_write_data), .sram_read_address(sram_read_address),
        .sram_read_data(sram_read_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) sram_read_data <= mem[sram_read_address];

    always @(negedge clk)
        if (sram_write_enable) begin
            wa_q.push_back(sram_write_address);
            wd_q.push_back(sram_write_data);
        end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: tally valid codes, remember the first message that lands a type on the threshold.
    function automatic logic [31:0] model(input logic [31:0] words[$]);
        logic [31:0] res = 0;
        for (int t = 0; t <= NT; t++) exp_cnt[t] = 0;
        foreach (words[i]) begin
            int c = int'(words[i] & 32'hff);
            if (c >= 1 && c <= NT && exp_cnt[c] < 255) begin
                exp_cnt[c]++;
                if (exp_cnt[c] == THR && res == 0) res = ((i + 1) << 16) | c;
            end
        end
        return res;
    endfunction

    task automatic run_job(input string tag, input logic [31:0] words[$], input bit hold);
        int n = words.size();
        int base, busy, nw;
        logic [31:0] er, hdr;
        er = model(words);
        hdr = $urandom;
        hdr[15:0] = 16'(n);
        mem[0] = hdr;
        foreach (words[i]) mem[i+1] = words[i];
        base = wa_q.size();
        @(negedge clk);
        dut_valid = 1'b1;
        @(posedge clk);
        #1;
        busy = 0;
        while (!dut_ready && busy < 500) begin
            busy++;
            dut_valid = hold ? 1'b1 : 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
        end
        dut_valid = 1'b0;
        chk({tag, " busy"}, busy, n + 4 + EXTRA);
        nw = wa_q.size() - base;
        chk({tag, " nwrites"}, nw, 1 + EXTRA);
        if (nw == 1 + EXTRA) begin
            chk({tag, " res_addr"}, 32'(wa_q[base]), n + 1);
            chk({tag, " res_data"}, wd_q[base], er);
            for (int t = 1; t <= EXTRA; t++) begin
                chk({tag, " st_addr"}, 32'(wa_q[base+t]), n + 1 + t);
                chk({tag, " st_data"}, wd_q[base+t], exp_cnt[t]);
            end
        end
        repeat (2) @(posedge clk);
        #1;
        chk({tag, " idle"}, 32'(wa_q.size() - base), 1 + EXTRA);
    endtask

    initial begin
        logic [31:0] q[$];
        int base;
        #1;
        chk("rst ready", dut_ready, 1);
        chk("rst we", sram_write_enable, 0);
        chk("rst waddr", sram_write_address, 0);
        chk("rst wdata", sram_write_data, 0);
        chk("rst raddr", sram_read_address, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        q = '{2, 1, 2, 3, 2};
        run_job("n5", q, 1'b0);
        q = '{1, 4, 4, 1, 4, 1};
        run_job("n6", q, 1'b1);
        q = '{32'hABCD_0000, 32'h1234_0007, 32'hFFFF_FF03, 3};
        run_job("n4", q, 1'b0);
        q.delete();
        run_job("n0", q, 1'b1);
        q = '{1, 1, 1};
        run_job("b2b1", q, 1'b1);
        q = '{2};
        run_job("b2b2", q, 1'b1);

        q.delete();
        for (int i = 0; i < 10; i++) q.push_back(32'(i % 4 + 1));
        foreach (q[i]) mem[i+1] = q[i];
        mem[0] = 10;
        base = wa_q.size();
        @(negedge clk);
        dut_valid = 1'b1;
        @(negedge clk);
        dut_valid = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("abort ready", dut_ready, 1);
        chk("abort we", sram_write_enable, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("abort nwrites", 32'(wa_q.size() - base), 0);
        chk("abort idle", dut_ready, 1);

        for (int j = 0; j < 25; j++) begin
            q.delete();
            for (int i = 0; i < int'($urandom_range(0, 24)); i++) begin
                logic [31:0] w = $urandom;
                w[7:0] = 8'($urandom_range(0, 6));
                q.push_back(w);
            end
            run_job($sformatf("rnd%0d", j), q, 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
